// File: rtl/spi_master_mc.sv
// rtl/spi_master_mc.sv - parametrised multi-mode SPI master with burst support
//
// Purpose: SPI master with configurable word width, NCS chip selects, all
// four CPOL/CPHA modes, programmable SCK divider and MSB/LSB-first order.
// Words arrive on a valid/ready request port; consecutive words keep CS
// asserted until a word flagged req_last completes.
//
// Ports:
//   CLK, RESET          system clock, synchronous active-high reset
//   cfg_div             SCK half-period = cfg_div+1 CLK cycles
//   cfg_cpol, cfg_cpha  SPI mode (latched when a transfer starts from IDLE)
//   cfg_lsb_first       1: LSB shifted first (TX and RX)
//   req_valid/ready     request handshake; req_cs, req_data, req_last payload
//   rsp_valid, rsp_data one-cycle pulse per received word, no backpressure
//   busy                high whenever the engine is not idle
//   spi_sck, spi_mosi, spi_miso, spi_cs_n   SPI pins
`timescale 1ns/1ps
module spi_master_mc #(
  parameter int DW   = 8,
  parameter int NCS  = 4,
  parameter int DIVW = 8,
  parameter int CSW  = $clog2(NCS)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [DIVW-1:0] cfg_div,
  input  logic            cfg_cpol,
  input  logic            cfg_cpha,
  input  logic            cfg_lsb_first,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [CSW-1:0]  req_cs,
  input  logic [DW-1:0]   req_data,
  input  logic            req_last,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            busy,
  output logic            spi_sck,
  output logic            spi_mosi,
  input  logic            spi_miso,
  output logic [NCS-1:0]  spi_cs_n
);

  localparam int EW = $clog2(2*DW);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_GAP, S_TRAIL} state_e;

  state_e          state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d, div_q, div_d;
  logic            cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, last_q, last_d;
  logic [DW-1:0]   tx_q, tx_d, rx_q, rx_d;
  logic            mosi_q, mosi_d, sck_q, sck_d;
  logic [NCS-1:0]  cs_n_q, cs_n_d;
  logic [EW-1:0]   ecnt_q, ecnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  logic tick, accept, leading, sample_edge, final_edge;

  function automatic logic first_bit(input logic [DW-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DW-1];
  endfunction

  function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  assign req_ready   = !RESET && (state_q == S_IDLE || state_q == S_GAP);
  assign accept      = req_valid && req_ready;
  assign tick        = (cnt_q == '0);
  // Edges are numbered from 1; odd (leading) edges have ecnt_q even.
  assign leading     = ~ecnt_q[0];
  assign sample_edge = leading ^ cpha_q;
  assign final_edge  = (ecnt_q == EW'(2*DW-1));

  assign busy      = (state_q != S_IDLE);
  // In IDLE the idle level follows the live config; otherwise the latched one.
  assign spi_sck   = (state_q == S_IDLE) ? cfg_cpol : sck_q;
  assign spi_mosi  = mosi_q;
  assign spi_cs_n  = cs_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    last_d      = last_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    mosi_d      = mosi_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    ecnt_d      = ecnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          div_d   = cfg_div;
          cpol_d  = cfg_cpol;
          cpha_d  = cfg_cpha;
          lsb_d   = cfg_lsb_first;
          last_d  = req_last;
          cs_n_d  = ~(NCS'(1) << req_cs);
          sck_d   = cfg_cpol;
          cnt_d   = cfg_div;
          ecnt_d  = '0;
          // CPHA=0 needs the first bit on MOSI before the first SCK edge.
          if (!cfg_cpha) begin
            mosi_d = first_bit(req_data, cfg_lsb_first);
            tx_d   = shift_out(req_data, cfg_lsb_first);
          end else begin
            tx_d   = req_data;
          end
          state_d = S_LEAD;
        end
      end
      S_GAP: begin
        if (accept) begin
          last_d = req_last;
          cnt_d  = div_q;
          ecnt_d = '0;
          if (!cpha_q) begin
            mosi_d = first_bit(req_data, lsb_q);
            tx_d   = shift_out(req_data, lsb_q);
          end else begin
            tx_d   = req_data;
          end
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (tick) begin
          cnt_d   = div_q;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q - DIVW'(1);
        end
      end
      S_SHIFT: begin
        if (tick) begin
          cnt_d = div_q;
          sck_d = ~sck_q;
          if (sample_edge) begin
            rx_d = lsb_q ? {spi_miso, rx_q[DW-1:1]} : {rx_q[DW-2:0], spi_miso};
          end else if (!final_edge) begin
            mosi_d = first_bit(tx_q, lsb_q);
            tx_d   = shift_out(tx_q, lsb_q);
          end
          if (final_edge) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_d;
            ecnt_d      = '0;
            state_d     = last_q ? S_TRAIL : S_GAP;
          end else begin
            ecnt_d = ecnt_q + EW'(1);
          end
        end else begin
          cnt_d = cnt_q - DIVW'(1);
        end
      end
      S_TRAIL: begin
        if (tick) begin
          cs_n_d  = '1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - DIVW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      last_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      mosi_q      <= 1'b0;
      sck_q       <= 1'b0;
      cs_n_q      <= '1;
      ecnt_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      last_q      <= last_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      mosi_q      <= mosi_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      ecnt_q      <= ecnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// tb/tb_spi_master_mc.sv - directed self-checking bench for spi_master_mc
`timescale 1ns/1ps
module tb_spi_master_mc;

  logic       CLK;
  logic       RESET;
  logic [7:0] cfg_div;
  logic       cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic       req_valid, req_ready;
  logic [1:0] req_cs;
  logic [7:0] req_data;
  logic       req_last;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       spi_sck, spi_mosi, spi_miso;
  logic [3:0] spi_cs_n;

  spi_master_mc #(.DW(8), .NCS(4), .DIVW(8)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .cfg_div       (cfg_div),
    .cfg_cpol      (cfg_cpol),
    .cfg_cpha      (cfg_cpha),
    .cfg_lsb_first (cfg_lsb_first),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cs        (req_cs),
    .req_data      (req_data),
    .req_last      (req_last),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .spi_sck       (spi_sck),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_cs_n      (spi_cs_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks, errors;
  int cyc, acc_cyc, lat;
  int n_edges, n_rise, n_rsp, cs_bad, hp_bad, mosi_bad, n_rdy_busy, miso_k, hp_exp, last_edge_cyc;
  logic [7:0]  mosi_rise, last_rsp, miso_word;
  logic [23:0] rsp_hist;
  logic        sck_prev, mosi_prev, chk_mosi_rise, miso_r;
  logic [1:0]  miso_sel;
  logic [3:0]  cs_exp;

  assign spi_miso = (miso_sel == 2'd0) ? spi_mosi : (miso_sel == 2'd1) ? 1'b1 : miso_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_edges = 0; n_rise = 0; n_rsp = 0; cs_bad = 0; hp_bad = 0; mosi_bad = 0;
    n_rdy_busy = 0; miso_k = 0; mosi_rise = '0; last_rsp = '0; rsp_hist = '0;
    last_edge_cyc = cyc;
    sck_prev = spi_sck; mosi_prev = spi_mosi;
    miso_r = miso_word[0];
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
    if (busy && spi_sck != sck_prev) begin
      n_edges++;
      if (n_edges > 1 && (cyc - last_edge_cyc) != hp_exp) hp_bad++;
      last_edge_cyc = cyc;
      if (spi_sck) begin
        n_rise++;
        mosi_rise = {mosi_rise[6:0], spi_mosi};
        miso_k++;
      end
    end
    if (chk_mosi_rise && busy && spi_mosi != mosi_prev && !(spi_sck && !sck_prev)) mosi_bad++;
    if (rsp_valid) begin
      n_rsp++;
      last_rsp = rsp_data;
      rsp_hist = {rsp_hist[15:0], rsp_data};
    end
    if (busy && spi_cs_n != cs_exp) cs_bad++;
    if (busy && req_ready) n_rdy_busy++;
    miso_r = (miso_k < 8) ? miso_word[miso_k[2:0]] : 1'b0;
    sck_prev = spi_sck;
    mosi_prev = spi_mosi;
  endtask

  task automatic send(input logic [1:0] cs, input logic [7:0] d, input logic last);
    int k;
    k = 0;
    req_valid = 1'b1; req_cs = cs; req_data = d; req_last = last;
    while (!req_ready && k < 500) begin step(); k++; end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    acc_cyc = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 2000) begin step(); k++; end
    check("idle_reached", {31'd0, busy}, 32'd0);
    lat = cyc - acc_cyc;
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic [7:0] div, input logic lsb);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_div = div; cfg_lsb_first = lsb;
    hp_exp = int'(div) + 1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; acc_cyc = 0; lat = 0;
    RESET = 1'b1; req_valid = 1'b0; req_cs = '0; req_data = '0; req_last = 1'b0;
    miso_sel = 2'd0; miso_word = '0; chk_mosi_rise = 1'b0; cs_exp = 4'hF;
    set_mode(1'b0, 1'b0, 8'd0, 1'b0);
    clr();
    repeat (3) step();

    // Reset state
    check("rst_cs_n", {28'd0, spi_cs_n}, 32'hF);
    check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sck_lo", {31'd0, spi_sck}, 32'd0);
    cfg_cpol = 1'b1;
    #1;
    check("rst_sck_hi", {31'd0, spi_sck}, 32'd1);
    cfg_cpol = 1'b0;
    step();
    RESET = 1'b0;
    step();
    check("idle_ready", {31'd0, req_ready}, 32'd1);

    // Mode 0, div 0, cs 2, 0xA5 loopback
    set_mode(1'b0, 1'b0, 8'd0, 1'b0);
    miso_sel = 2'd0; cs_exp = 4'b1011;
    clr();
    send(2'd2, 8'hA5, 1'b1);
    wait_idle();
    check("m0_rises", n_rise, 8);
    check("m0_mosi_seq", {24'd0, mosi_rise}, 32'hA5);
    check("m0_rsp_data", {24'd0, last_rsp}, 32'hA5);
    check("m0_rsp_count", n_rsp, 1);
    check("m0_cs_held", cs_bad, 0);
    check("m0_latency", lat, 19);
    check("m0_cs_release", {28'd0, spi_cs_n}, 32'hF);

    // Mode 3, div 3, MISO tied 1, cpol toggled mid-transfer
    set_mode(1'b1, 1'b1, 8'd3, 1'b0);
    miso_sel = 2'd1; cs_exp = 4'b1110;
    step();
    check("m3_sck_idle", {31'd0, spi_sck}, 32'd1);
    clr();
    send(2'd0, 8'h00, 1'b1);
    repeat (20) step();
    cfg_cpol = 1'b0;
    wait_idle();
    check("m3_edges", n_edges, 16);
    check("m3_half_period", hp_bad, 0);
    check("m3_rsp_data", {24'd0, last_rsp}, 32'hFF);
    check("m3_latency", lat, 73);
    check("m3_cs_held", cs_bad, 0);

    // Burst 0x01,0x02,0x03 with req_cs changed during GAP
    set_mode(1'b0, 1'b0, 8'd0, 1'b0);
    miso_sel = 2'd0; cs_exp = 4'b1101;
    step();
    clr();
    send(2'd1, 8'h01, 1'b0);
    send(2'd3, 8'h02, 1'b0);
    send(2'd3, 8'h03, 1'b1);
    wait_idle();
    check("burst_rsp_count", n_rsp, 3);
    check("burst_rsp_seq", {8'd0, rsp_hist}, 32'h010203);
    check("burst_cs_held", cs_bad, 0);
    check("burst_ready_gap", n_rdy_busy, 2);
    check("burst_cs_release", {28'd0, spi_cs_n}, 32'hF);

    // LSB first, data 0x80, MISO supplies 0x01 LSB first
    set_mode(1'b0, 1'b0, 8'd0, 1'b1);
    miso_sel = 2'd2; miso_word = 8'h01; cs_exp = 4'b1110;
    step();
    clr();
    send(2'd0, 8'h80, 1'b1);
    wait_idle();
    check("lsb_first_bit", {31'd0, mosi_rise[7]}, 32'd0);
    check("lsb_last_bit", {31'd0, mosi_rise[0]}, 32'd1);
    check("lsb_mosi_seq", {24'd0, mosi_rise}, 32'h01);
    check("lsb_rsp_data", {24'd0, last_rsp}, 32'h01);

    // Mode 1, div 1, 0x3C loopback
    set_mode(1'b0, 1'b1, 8'd1, 1'b0);
    miso_sel = 2'd0; cs_exp = 4'b0111; chk_mosi_rise = 1'b1;
    step();
    clr();
    send(2'd3, 8'h3C, 1'b1);
    wait_idle();
    chk_mosi_rise = 1'b0;
    check("m1_mosi_on_rise", mosi_bad, 0);
    check("m1_edges", n_edges, 16);
    check("m1_half_period", hp_bad, 0);
    check("m1_rsp_data", {24'd0, last_rsp}, 32'h3C);
    check("m1_latency", lat, 37);

    // Reset after the 5th SHIFT edge
    set_mode(1'b0, 1'b0, 8'd0, 1'b0);
    cs_exp = 4'b1110;
    step();
    clr();
    send(2'd0, 8'hC3, 1'b1);
    begin
      int k;
      k = 0;
      while (n_edges < 5 && k < 200) begin step(); k++; end
    end
    check("rr_edge5", n_edges, 5);
    RESET = 1'b1;
    step();
    check("rr_cs_n", {28'd0, spi_cs_n}, 32'hF);
    check("rr_sck", {31'd0, spi_sck}, 32'd0);
    check("rr_busy", {31'd0, busy}, 32'd0);
    check("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    RESET = 1'b0;
    clr();
    repeat (40) step();
    check("rr_no_rsp", n_rsp, 0);
    clr();
    send(2'd0, 8'h5A, 1'b1);
    wait_idle();
    check("rr_after_rsp", {24'd0, last_rsp}, 32'h5A);
    check("rr_after_count", n_rsp, 1);
    check("rr_after_latency", lat, 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
